// File: rtl/testram_pkg.sv
// Shared widths and sequencer state encoding for the self-initialising test RAM.
package testram_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/testram_init_seq.sv
// Post-reset fill sequencer: walks ptr over every address once, then raises ready and idles.
module testram_init_seq
    import testram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  fill_we,
    output logic                  ready
);

    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

    state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FILL;
            ptr   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    // ptr wraps to zero on the last fill edge and is left there in RUN
                    ptr <= ptr + 1'b1;
                    if (ptr == PTR_LAST) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_FILL;
                    ptr   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // A reset edge must never write storage, even while the state still reads FILL.
    assign fill_we = (state == ST_FILL) && !rst;

endmodule

// File: rtl/testram.sv
// Asynchronous-read test RAM with active-low strobes on a shared tristate bus;
// after reset every word is preloaded with its own address before access opens.
module testram
    import testram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WE,
    input  logic                  OE,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    inout  wire  [DATA_WIDTH-1:0] DATA,
    output logic                  READY
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] ptr;
    logic                  fill_we;
    logic                  ready;
    logic [DATA_WIDTH-1:0] fill_word;
    logic                  ext_we;
    logic                  rd_en;

    testram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .clk     (CLK),
        .rst     (RST),
        .ptr     (ptr),
        .fill_we (fill_we),
        .ready   (ready)
    );

    // Size cast zero-extends or truncates the pointer as the widths demand.
    assign fill_word = DATA_WIDTH'(ptr);

    assign ext_we = ready && !WE && !RST;

    always_ff @(posedge CLK) begin
        if (fill_we) begin
            mem[ptr] <= fill_word;
        end else if (ext_we) begin
            mem[ADDR] <= DATA;
        end
    end

    // Write strobe suppresses the driver so a simultaneous WE/OE never fights the bus master.
    assign rd_en = ready && !OE && WE;
    assign DATA  = rd_en ? mem[ADDR] : {DATA_WIDTH{1'bz}};

    assign READY = ready;

endmodule

// File: tb/tb_testram.sv
// Randomised self-checking bench for testram against an array reference model.
module tb_testram;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          WE;
    logic          OE;
    logic [AW-1:0] ADDR;
    wire  [DW-1:0] DATA;
    logic          READY;

    logic [DW-1:0] bus_val;
    logic          bus_en;

    assign DATA = bus_en ? bus_val : {DW{1'bz}};

    testram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .WE    (WE),
        .OE    (OE),
        .ADDR  (ADDR),
        .DATA  (DATA),
        .READY (READY)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model [0:DEPTH-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic edge_tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference fill: every word holds its own address.
    task automatic model_fill();
        for (int a = 0; a < DEPTH; a++) model[a] = DW'(a);
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic oe);
        ADDR = a; bus_val = d; bus_en = 1'b1; WE = 1'b0; OE = oe;
        edge_tick();
        model[a] = d;
        WE = 1'b1; OE = 1'b1; bus_en = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [AW-1:0] a);
        ADDR = a; WE = 1'b1; OE = 1'b0; bus_en = 1'b0;
        #1;
        check(tag, DATA, model[a]);
        OE = 1'b1;
    endtask

    task automatic run_fill(input bit probe, output int edges);
        edges = 0;
        for (int i = 0; i < 1500; i++) begin
            WE = 1'b1; OE = 1'b1; bus_en = 1'b0;
            if (probe && i == 20) begin
                WE = 1'b0; ADDR = 10'h007; bus_val = 16'hFFFF; bus_en = 1'b1;
            end else if (probe && i == 21) begin
                // bench holds zero on the bus; any DUT drive shows up as nonzero or X
                OE = 1'b0; ADDR = 10'h002; bus_val = 16'h0000; bus_en = 1'b1;
                #1;
                check("fill_bus_released", DATA, 32'h0);
            end
            edge_tick();
            edges = i + 1;
            if (READY === 1'b1) break;
        end
        WE = 1'b1; OE = 1'b1; bus_en = 1'b0;
    endtask

    int            n_edges;
    logic [DW-1:0] v;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    initial begin
        RST = 1'b1; WE = 1'b1; OE = 1'b1; ADDR = '0; bus_val = '0; bus_en = 1'b0;
        edge_tick();
        check("reset_ready", READY, 32'h0);
        RST = 1'b0;

        run_fill(1'b1, n_edges);
        check("fill_length", n_edges, DEPTH);
        check("ready_after_fill", READY, 32'h1);
        model_fill();

        bus_read("read_0x234", 10'h234);
        bus_read("fill_write_ignored", 10'h007);

        bus_write(10'h005, 16'hBEEF, 1'b1);
        bus_read("read_back_beef", 10'h005);
        bus_read("neighbour_0x006", 10'h006);

        // idle strobes and write-only strobes: bench drives zero, DUT must stay off
        ADDR = 10'h005; WE = 1'b1; OE = 1'b1; bus_val = '0; bus_en = 1'b1; #1;
        check("idle_bus_released", DATA, 32'h0);
        WE = 1'b0; #1;
        check("we_only_bus_released", DATA, 32'h0);
        WE = 1'b1; bus_en = 1'b0;

        // write wins over output enable
        ADDR = 10'h009; WE = 1'b0; OE = 1'b0; bus_val = 16'hA5A5; bus_en = 1'b1; #1;
        check("we_oe_no_contention", DATA, 32'hA5A5);
        edge_tick();
        model[10'h009] = 16'hA5A5;
        WE = 1'b1; OE = 1'b1; bus_en = 1'b0;
        bus_read("we_oe_stored", 10'h009);

        for (int k = 0; k < 3; k++) begin
            ADDR = 10'h000; WE = 1'b1; OE = 1'b0; bus_en = 1'b0; #1;
            check($sformatf("rmw_read_%0d", k), DATA, k);
            rd = DATA;
            OE = 1'b1;
            bus_write(10'h000, rd + 16'd1, 1'b1);
        end
        bus_read("rmw_final", 10'h000);

        for (int k = 0; k < 400; k++) begin
            ra = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 2) == 0) begin
                v = DW'($urandom);
                ADDR = ra; WE = 1'b0; OE = 1'($urandom_range(0, 1));
                bus_val = v; bus_en = 1'b1; #1;
                check("rnd_wr_bus", DATA, v);
                edge_tick();
                model[ra] = v;
                WE = 1'b1; OE = 1'b1; bus_en = 1'b0;
            end else begin
                bus_read("rnd_rd", ra);
            end
        end

        // mid-RUN reset reloads the whole array
        bus_write(10'h005, 16'hBEEF, 1'b1);
        RST = 1'b1;
        edge_tick();
        check("ready_drops_on_reset", READY, 32'h0);
        RST = 1'b0;
        run_fill(1'b0, n_edges);
        check("refill_length", n_edges, DEPTH);
        model_fill();
        bus_read("refill_0x005", 10'h005);
        bus_read("refill_0x009", 10'h009);
        for (int k = 0; k < 20; k++) begin
            bus_read("refill_rnd", AW'($urandom_range(0, DEPTH - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/testram.md
TESTRAM -- requirements
Module: testram

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 16, the address bus width; depth = 2^ADDR_WIDTH words.
REQ-002 SHALL provide parameter DATA_WIDTH, default 16, the word width.
REQ-003 SHALL have one clock and a synchronous, active-high reset; ports listed below.
REQ-004 CLK  input  1  sole clock; all state changes on rising edge.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 WE  input  1  write enable, active-low.
REQ-007 OE  input  1  output enable, active-low.
REQ-008 ADDR  input  ADDR_WIDTH  word address.
REQ-009 DATA  inout  DATA_WIDTH  bidirectional data bus; high-impedance whenever not reading.
REQ-010 READY  output  1  high once the post-reset fill has completed.

Function
REQ-011 SHALL contain a 2^ADDR_WIDTH x DATA_WIDTH storage array.
REQ-012 SHALL implement two states: FILL and RUN.
REQ-013 FILL: each cycle write mem[ptr] = ptr (truncated or zero-extended to DATA_WIDTH); ptr increments by 1.
REQ-014 FILL -> RUN on the edge that writes ptr = 2^ADDR_WIDTH-1; READY = 1 from that edge onward.
REQ-015 FILL therefore lasts exactly 2^ADDR_WIDTH cycles after RST deasserts; ptr wraps to 0 and stays unused in RUN.
REQ-016 RUN write: on a rising CLK with WE=0, mem[ADDR] <= DATA (value sampled from the bus at the edge).
REQ-017 RUN read: DATA is driven combinationally with mem[ADDR] iff READY=1, OE=0 and WE=1; otherwise DATA = Z.
REQ-018 Read data SHALL follow ADDR changes with no clock latency; a word written at an edge is readable immediately after that edge.
REQ-019 WE=0 with OE=0 simultaneously: the write SHALL occur and DATA SHALL NOT be driven (write wins, no contention).
REQ-020 WE and OE during FILL SHALL be ignored: no external writes, DATA stays Z.
REQ-021 Consecutive write cycles to different addresses SHALL each complete in one clock; no wait states in RUN.

Reset
REQ-022 On RST=1 at a rising edge: state <= FILL, ptr <= 0, READY <= 0, DATA released to Z.
REQ-023 RST asserted mid-FILL or mid-RUN SHALL restart the fill from address 0, overwriting all prior contents.
REQ-024 While RST=1, no storage writes SHALL occur.

Structure
REQ-025 Default widths ADDR_WIDTH/DATA_WIDTH and the FILL/RUN state encoding SHALL live in shared package testram_pkg.
REQ-026 The fill pointer and state machine SHALL be one sub-module, testram_init_seq (outputs ptr, fill write strobe, READY); storage and bus logic remain in testram.

Verification
REQ-027 RST 1 cycle, then idle: READY=0 for 65536 cycles, then READY=1; then ADDR=0x1234, WE=1, OE=0 -> DATA=0x1234.
REQ-028 In RUN: ADDR=0x0005, DATA=0xBEEF, WE=0 for one edge; then WE=1, OE=0 -> DATA=0xBEEF; ADDR=0x0006 -> DATA=0x0006.
REQ-029 WE=0, OE=1 with bench releasing the bus -> DATA=Z; WE=0, OE=0, DATA=0xA5A5 driven by bench -> no contention (no X), mem[ADDR] becomes 0xA5A5.
REQ-030 Write WE=0, ADDR=0x0007, DATA=0xFFFF during FILL -> after READY, reading 0x0007 returns 0x0007.
REQ-031 Read-increment-write loop on ADDR=0x0000 three times -> reads 0x0000, 0x0001, 0x0002; final read 0x0003.
REQ-032 Write 0xBEEF to 0x0005, pulse RST -> READY drops next edge, and after a new fill reading 0x0005 returns 0x0005.
